mul_cmd_dispatcher: RTL and testbench
=====================================

Name: mul_cmd_dispatcher

Overview:
- Parametrised successor to the single-channel stimulus driver that feeds MUL_controller.
- Accepts compute and external load/store (ExLdSt) commands from a host through a valid/ready port and buffers them in an in-order FIFO.
- Dispatches each entry to one of NUM_CH MUL_controller channels: Compute commands use the controller's valid/ready handshake; ExLdSt commands are single-cycle pulses followed by a programmable guard gap.

Parameters:
- CMD_W, 25, compute command width.
- LDST_W, 7, ExLdSt command width; taken from host_cmd[LDST_W-1:0].
- ROW_NUM, 16, ExLdSt data width.
- NUM_CH, 2, number of MUL_controller channels, 1..8.
- CH_W, 3, channel-select width; must satisfy 2^CH_W >= NUM_CH.
- FIFO_DEPTH, 8, command FIFO entries; must be a power of two and >= 2.
- LDST_GAP, 1, idle cycles after each ExLdSt pulse, 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- host_valid  in  1  host entry valid.
- host_ready  out  1  FIFO can accept an entry.
- host_is_ldst  in  1  1 = ExLdSt entry, 0 = Compute entry.
- host_ch  in  CH_W  target channel.
- host_cmd  in  CMD_W  command payload.
- host_ldst_data  in  ROW_NUM  ExLdSt data; ignored for Compute entries.
- Compute_valid  out  NUM_CH  per-channel compute valid.
- Compute_ready  in  NUM_CH  per-channel compute ready.
- Compute_command  out  NUM_CH*CMD_W  channel i occupies slice [i*CMD_W +: CMD_W].
- ExLdSt_valid  out  NUM_CH  per-channel ExLdSt pulse.
- ExLdSt_command  out  NUM_CH*LDST_W  per-channel slice.
- ExLdSt_data  out  NUM_CH*ROW_NUM  per-channel slice; driven only while the matching ExLdSt_valid is high, else 0.
- fifo_count  out  CH_W+4  occupied FIFO entries, 0..FIFO_DEPTH.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- issued_cnt  out  16  count of completed dispatches; wraps 0xFFFF -> 0x0000.
- err_ch  out  1  sticky flag: an entry with host_ch >= NUM_CH was accepted.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - all outputs 0 except host_ready = 1;
  - FIFO emptied, FSM to IDLE, issued_cnt = 0, err_ch = 0.
  - Reset mid-transaction drops any asserted valid at that edge; the in-flight entry is lost.
- Push:
  - Occurs when host_valid && host_ready.
  - host_ready = (fifo_count != FIFO_DEPTH), registered.
  - When full, push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full leaves fifo_count unchanged.
- FSM states: IDLE, CMP, LDST, GAP.
- IDLE:
  - If FIFO non-empty, pop head at the edge and load output registers.
  - is_ldst = 0 -> CMP; is_ldst = 1 -> LDST.
  - Entries with ch >= NUM_CH are popped and discarded with no output and no issued_cnt increment; FSM stays IDLE.
- CMP:
  - Compute_valid[ch] = 1 with its command slice held stable until Compute_ready[ch] is sampled high.
  - On handshake: issued_cnt += 1.
  - If the FIFO is non-empty, pop the next head at the same edge (back-to-back, no bubble); else go to IDLE.
  - Other channels' valids remain 0. Strictly one outstanding command at a time, in order.
- LDST:
  - ExLdSt_valid[ch], command and data are high for exactly one cycle; issued_cnt += 1.
  - Next state is GAP if LDST_GAP > 0, else behave as IDLE at the same edge (pop next entry or go to IDLE).
- GAP:
  - A 4-bit counter counts LDST_GAP cycles with all valids 0, then returns to IDLE.
- Latency: a host handshake at edge N into an empty FIFO with the FSM in IDLE produces valid high during the cycle after edge N+1.
- err_ch is set at push time; it is cleared only by rst.
- Compute_ready for a channel that is not being driven is ignored.

Test Plan:
- Reset and fill: hold Compute_ready = 0 and push 9 Compute entries to ch0 with DEPTH = 8 -> host_ready = 0 with fifo_count = 8 after the FIFO fills (the first pop occurs during filling), extra pushes refused, Compute_valid[0] = 1 held with a stable command; rst high for one edge -> all outputs 0, host_ready = 1.
- Back-to-back compute: push cmd 0x0000001, 0x0000002 to ch1, tie Compute_ready[1] = 1 -> valid high for 2 consecutive cycles with commands 1 then 2; issued_cnt = 2.
- Ready stall: Compute_ready[0] low for 5 cycles then high -> command stable for all 6 valid cycles, single issued_cnt increment.
- ExLdSt with gap: LDST_GAP = 3, push LDST cmd 0x15 data 0xA5A5 to ch0 followed by a Compute entry -> 1-cycle ExLdSt pulse with 0x15/0xA5A5, 3 idle cycles, then Compute_valid.
- Bad channel: NUM_CH = 2, push host_ch = 3 -> err_ch = 1, no valid asserted on any channel, issued_cnt unchanged, next good entry dispatched normally.
- Wrap: preset issued_cnt path via 65536 dispatches (or a forced value) -> 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/mul_cmd_dispatcher_if.sv
// Host-side command port of mul_cmd_dispatcher: one entry per valid/ready handshake.
// Latency: none, this is wiring only.
// Backpressure: the host holds its entry while host_ready is low.
interface mul_cmd_dispatcher_if #(
  parameter int CMD_W   = 25,
  parameter int ROW_NUM = 16,
  parameter int CH_W    = 3
) ();
  logic               host_valid;
  logic               host_ready;
  logic               host_is_ldst;
  logic [CH_W-1:0]    host_ch;
  logic [CMD_W-1:0]   host_cmd;
  logic [ROW_NUM-1:0] host_ldst_data;

  // Host side: drives the entry and watches ready.
  modport master (
    output host_valid, host_is_ldst, host_ch, host_cmd, host_ldst_data,
    input  host_ready
  );

  // Dispatcher side: consumes the entry and drives ready.
  modport slave (
    input  host_valid, host_is_ldst, host_ch, host_cmd, host_ldst_data,
    output host_ready
  );
endinterface

// File: rtl/mul_cmd_dispatcher.sv
// Buffers host Compute/ExLdSt entries in order and dispatches them to NUM_CH MUL_controller channels.
// Latency: handshake at edge N into an idle, empty block gives channel valid in the cycle after edge N+1.
// Backpressure: host_ready falls when the FIFO is full; a Compute dispatch holds until Compute_ready.
module mul_cmd_dispatcher #(
  parameter int CMD_W      = 25,
  parameter int LDST_W     = 7,
  parameter int ROW_NUM    = 16,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int LDST_GAP   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  mul_cmd_dispatcher_if.slave         host,
  output logic [NUM_CH-1:0]           Compute_valid,
  input  logic [NUM_CH-1:0]           Compute_ready,
  output logic [NUM_CH*CMD_W-1:0]     Compute_command,
  output logic [NUM_CH-1:0]           ExLdSt_valid,
  output logic [NUM_CH*LDST_W-1:0]    ExLdSt_command,
  output logic [NUM_CH*ROW_NUM-1:0]   ExLdSt_data,
  output logic [CH_W+3:0]             fifo_count,
  output logic                        busy,
  output logic [15:0]                 issued_cnt,
  output logic                        err_ch
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = CH_W + 4;
  localparam logic [CH_W:0]    NUM_CH_X = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DEPTH_X  = CNT_W'(FIFO_DEPTH);
  // Gap counter runs GAP_LAST..0; the final GAP cycle dispatches like IDLE,
  // so exactly LDST_GAP quiet cycles separate a pulse from the next valid.
  localparam logic [3:0]       GAP_LAST = 4'(LDST_GAP - 1);

  typedef struct packed {
    logic               is_ldst;
    logic [CH_W-1:0]    ch;
    logic [CMD_W-1:0]   cmd;
    logic [ROW_NUM-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_LDST, S_GAP} state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  gap_cnt_q, gap_cnt_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        host_ready_q, host_ready_d;
  logic [15:0]                 issued_q, issued_d;
  logic                        err_q, err_d;
  logic [NUM_CH-1:0]           cv_q, cv_d;
  logic [NUM_CH*CMD_W-1:0]     cc_q, cc_d;
  logic [NUM_CH-1:0]           lv_q, lv_d;
  logic [NUM_CH*LDST_W-1:0]    lc_q, lc_d;
  logic [NUM_CH*ROW_NUM-1:0]   ld_q, ld_d;
  entry_t                      fifo_mem_q [FIFO_DEPTH];
  entry_t                      fifo_mem_d [FIFO_DEPTH];

  entry_t head;
  logic   push;
  logic   pop;
  logic   take_next;
  logic   handshake;

  // Next-state: FIFO bookkeeping, dispatch FSM and registered channel outputs.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    issued_d   = issued_q;
    err_d      = err_q;
    fifo_mem_d = fifo_mem_q;
    cv_d       = cv_q;
    cc_d       = cc_q;
    lv_d       = lv_q;
    lc_d       = lc_q;
    ld_d       = ld_q;
    head       = fifo_mem_q[rd_ptr_q];
    push       = host.host_valid && host_ready_q;
    pop        = 1'b0;
    take_next  = 1'b0;
    // Ready on channels that are not being driven is masked out here.
    handshake  = |(cv_q & Compute_ready);

    case (state_q)
      S_IDLE: take_next = 1'b1;
      S_CMP: begin
        if (handshake) begin
          issued_d  = issued_q + 16'd1;
          take_next = 1'b1;
        end
      end
      S_LDST: begin
        // The pulse lasts exactly this one cycle.
        issued_d = issued_q + 16'd1;
        lv_d     = '0;
        lc_d     = '0;
        ld_d     = '0;
        if (LDST_GAP > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LAST;
        end else begin
          take_next = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) take_next = 1'b1;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Dispatch slot: pop the head and load one channel's outputs.
    // A head whose channel matches no existing channel loads nothing, so it
    // is discarded silently and the FSM stays in IDLE.
    if (take_next) begin
      state_d = S_IDLE;
      cv_d    = '0;
      cc_d    = '0;
      lv_d    = '0;
      lc_d    = '0;
      ld_d    = '0;
      if (cnt_q != '0) begin
        pop = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (head.ch == CH_W'(i)) begin
            if (head.is_ldst) begin
              lv_d[i]                     = 1'b1;
              lc_d[i*LDST_W +: LDST_W]    = head.cmd[LDST_W-1:0];
              ld_d[i*ROW_NUM +: ROW_NUM]  = head.data;
              state_d                     = S_LDST;
            end else begin
              cv_d[i]                     = 1'b1;
              cc_d[i*CMD_W +: CMD_W]      = head.cmd;
              state_d                     = S_CMP;
            end
          end
        end
      end
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = '{is_ldst: host.host_is_ldst, ch: host.host_ch,
                               cmd: host.host_cmd, data: host.host_ldst_data};
      wr_ptr_d = wr_ptr_q + 1'b1;
      if ({1'b0, host.host_ch} >= NUM_CH_X) err_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    // Ready is registered from the next count, so a full FIFO refuses a push
    // even in a cycle where it also pops.
    host_ready_d = (cnt_d != DEPTH_X);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gap_cnt_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      host_ready_q <= 1'b1;
      issued_q     <= '0;
      err_q        <= 1'b0;
      cv_q         <= '0;
      cc_q         <= '0;
      lv_q         <= '0;
      lc_q         <= '0;
      ld_q         <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      host_ready_q <= host_ready_d;
      issued_q     <= issued_d;
      err_q        <= err_d;
      cv_q         <= cv_d;
      cc_q         <= cc_d;
      lv_q         <= lv_d;
      lc_q         <= lc_d;
      ld_q         <= ld_d;
    end
  end

  // Entry storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign host.host_ready  = host_ready_q;
  assign Compute_valid    = cv_q;
  assign Compute_command  = cc_q;
  assign ExLdSt_valid     = lv_q;
  assign ExLdSt_command   = lc_q;
  assign ExLdSt_data      = ld_q;
  assign fifo_count       = cnt_q;
  assign busy             = (cnt_q != '0) || (state_q != S_IDLE);
  assign issued_cnt       = issued_q;
  assign err_ch           = err_q;

endmodule

// File: tb/tb_mul_cmd_dispatcher.sv
// Bench for mul_cmd_dispatcher: vector table, hand-written corner sequences, random run against a queue model.
// Latency: checks the one-cycle-after-pop dispatch timing and the ExLdSt guard gap.
// Backpressure: exercises a full FIFO and Compute_ready stalls.
module tb_mul_cmd_dispatcher;
  localparam int CMD_W = 25, LDST_W = 7, ROW_NUM = 16, NUM_CH = 2, CH_W = 3;
  localparam int FIFO_DEPTH = 8, LDST_GAP = 3, RAND_N = 600;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_CH-1:0]         Compute_valid, Compute_ready, ExLdSt_valid;
  logic [NUM_CH*CMD_W-1:0]   Compute_command;
  logic [NUM_CH*LDST_W-1:0]  ExLdSt_command;
  logic [NUM_CH*ROW_NUM-1:0] ExLdSt_data;
  logic [CH_W+3:0]           fifo_count;
  logic                      busy, err_ch;
  logic [15:0]               issued_cnt;

  mul_cmd_dispatcher_if #(.CMD_W(CMD_W), .ROW_NUM(ROW_NUM), .CH_W(CH_W)) hif ();

  mul_cmd_dispatcher #(
    .CMD_W(CMD_W), .LDST_W(LDST_W), .ROW_NUM(ROW_NUM), .NUM_CH(NUM_CH),
    .CH_W(CH_W), .FIFO_DEPTH(FIFO_DEPTH), .LDST_GAP(LDST_GAP)
  ) dut (
    .clk(clk), .rst(rst), .host(hif),
    .Compute_valid(Compute_valid), .Compute_ready(Compute_ready),
    .Compute_command(Compute_command), .ExLdSt_valid(ExLdSt_valid),
    .ExLdSt_command(ExLdSt_command), .ExLdSt_data(ExLdSt_data),
    .fifo_count(fifo_count), .busy(busy), .issued_cnt(issued_cnt), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit l, input int ch, input logic [CMD_W-1:0] c, input logic [ROW_NUM-1:0] d);
    hif.host_valid     = 1'b1;
    hif.host_is_ldst   = l;
    hif.host_ch        = CH_W'(ch);
    hif.host_cmd       = c;
    hif.host_ldst_data = d;
  endtask

  task automatic do_reset();
    hif.host_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_cv"},     Compute_valid, 0);
    chk({tag, "_ccmd"},   Compute_command, 0);
    chk({tag, "_lv"},     ExLdSt_valid, 0);
    chk({tag, "_lcmd"},   ExLdSt_command, 0);
    chk({tag, "_ldata"},  ExLdSt_data, 0);
    chk({tag, "_count"},  fifo_count, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_issued"}, issued_cnt, 0);
    chk({tag, "_err"},    err_ch, 0);
    chk({tag, "_ready"},  hif.host_ready, 1);
  endtask

  function automatic int first_bit(input logic [NUM_CH-1:0] v);
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [ROW_NUM-1:0] or_data();
    logic [ROW_NUM-1:0] r = '0;
    for (int i = 0; i < NUM_CH; i++) r |= ExLdSt_data[i*ROW_NUM +: ROW_NUM];
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit                 l;
    int                 ch;
    logic [CMD_W-1:0]   cmd;
    logic [ROW_NUM-1:0] data;
    logic [NUM_CH-1:0]  ecv;
    logic [NUM_CH-1:0]  elv;
    logic [CMD_W-1:0]   ecmd;
    logic [ROW_NUM-1:0] edata;
    int                 efirst;
    int                 einc;
    bit                 eerr;
  } vec_t;
  vec_t vt [8];

  // ---------------- transaction-level model ----------------
  typedef struct {
    bit                 l;
    int                 ch;
    logic [CMD_W-1:0]   cmd;
    logic [ROW_NUM-1:0] data;
  } ent_t;
  ent_t              exp_q [$];
  int                model_issued;
  bit                model_err;
  int                last_pulse;
  bit                stall_prev;
  logic [NUM_CH-1:0] prev_cv;
  logic [NUM_CH*CMD_W-1:0] prev_cmd;

  // Compares one cycle of DUT outputs with the model; called at the falling edge.
  task automatic monitor(input int cyc);
    logic [NUM_CH-1:0] cv, lv;
    int nv, idx;
    bit is_l;
    ent_t h, e;
    cv = Compute_valid;
    lv = ExLdSt_valid;
    chk("rnd_ready_vs_count", hif.host_ready, fifo_count != FIFO_DEPTH);
    chk("rnd_count_bound", fifo_count <= FIFO_DEPTH, 1);
    chk("rnd_issued", issued_cnt, 16'(model_issued));
    chk("rnd_err", err_ch, model_err);
    chk("rnd_idle_data", or_data() & {ROW_NUM{lv == '0}}, 0);
    nv = $countones({cv, lv});
    chk("rnd_onehot", nv <= 1, 1);
    if (stall_prev) chk("rnd_stall_hold", {cv, Compute_command}, {prev_cv, prev_cmd});
    if (nv == 1) begin
      is_l = (lv != '0);
      idx  = is_l ? first_bit(lv) : first_bit(cv);
      chk("rnd_gap", cyc - last_pulse > LDST_GAP, 1);
      if (exp_q.size() == 0) begin
        chk("rnd_spurious", nv, 0);
      end else begin
        h = exp_q[0];
        chk("rnd_ch", idx, h.ch);
        chk("rnd_kind", is_l, h.l);
        if (is_l) begin
          chk("rnd_lcmd", ExLdSt_command[idx*LDST_W +: LDST_W], h.cmd[LDST_W-1:0]);
          chk("rnd_ldata", ExLdSt_data[idx*ROW_NUM +: ROW_NUM], h.data);
        end else begin
          chk("rnd_ccmd", Compute_command[idx*CMD_W +: CMD_W], h.cmd);
        end
        if (is_l || Compute_ready[idx]) begin
          void'(exp_q.pop_front());
          model_issued++;
        end
      end
      if (is_l) last_pulse = cyc;
    end
    stall_prev = (cv != '0) && ((cv & Compute_ready) == '0);
    prev_cv    = cv;
    prev_cmd   = Compute_command;
    if (hif.host_valid && hif.host_ready) begin
      if (int'(hif.host_ch) < NUM_CH) begin
        e = '{hif.host_is_ldst, int'(hif.host_ch), hif.host_cmd, hif.host_ldst_data};
        exp_q.push_back(e);
      end else begin
        model_err = 1'b1;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first, idx, base, pushed, seen;
    logic [NUM_CH-1:0] ocv, olv;
    logic [CMD_W-1:0] ocmd;
    logic [ROW_NUM-1:0] odata;
    bit a, hs, drained, done, seen_ffff;
    int gexp_lv [6] = '{1, 0, 0, 0, 0, 0};
    int gexp_cv [6] = '{0, 0, 0, 0, 1, 0};

    //            l  ch  cmd           data      ecv    elv    ecmd          edata     first inc err
    vt[0] = '{0, 0, 25'h0000001, 16'h0000, 2'b01, 2'b00, 25'h0000001, 16'h0000, 0, 1, 0};
    vt[1] = '{0, 1, 25'h1FFFFFF, 16'h1234, 2'b10, 2'b00, 25'h1FFFFFF, 16'h0000, 0, 1, 0};
    vt[2] = '{1, 1, 25'h0ABCD95, 16'hFFFF, 2'b00, 2'b10, 25'h0000015, 16'hFFFF, 0, 1, 0};
    vt[3] = '{1, 0, 25'h0000000, 16'h0001, 2'b00, 2'b01, 25'h0000000, 16'h0001, 0, 1, 0};
    vt[4] = '{0, 0, 25'h0AAAAAA, 16'hBEEF, 2'b01, 2'b00, 25'h0AAAAAA, 16'h0000, 0, 1, 0};
    vt[5] = '{0, 2, 25'h0000123, 16'h0000, 2'b00, 2'b00, 25'h0000000, 16'h0000, -1, 0, 1};
    vt[6] = '{1, 7, 25'h000007F, 16'h5555, 2'b00, 2'b00, 25'h0000000, 16'h0000, -1, 0, 1};
    vt[7] = '{0, 1, 25'h1555555, 16'h0000, 2'b10, 2'b00, 25'h1555555, 16'h0000, 0, 1, 1};

    hif.host_valid = 1'b0; hif.host_is_ldst = 1'b0; hif.host_ch = '0;
    hif.host_cmd = '0; hif.host_ldst_data = '0;
    Compute_ready = '0;

    do_reset();
    check_reset_state("rst0");

    // ---- table: one entry at a time into an idle block ----
    Compute_ready = '1;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      base = int'(issued_cnt);
      drive(vt[r].l, vt[r].ch, vt[r].cmd, vt[r].data);
      tick();
      hif.host_valid = 1'b0;
      tick();
      first = -1; ocv = '0; olv = '0; ocmd = '0; odata = '0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (first < 0 && (Compute_valid | ExLdSt_valid) != '0) begin
          first = k; ocv = Compute_valid; olv = ExLdSt_valid;
          idx   = (olv != '0) ? first_bit(olv) : first_bit(ocv);
          ocmd  = (olv != '0) ? CMD_W'(ExLdSt_command[idx*LDST_W +: LDST_W])
                              : Compute_command[idx*CMD_W +: CMD_W];
          odata = or_data();
        end
        tick();
      end
      @(negedge clk);
      chk($sformatf("vec%0d_cv", r), ocv, vt[r].ecv);
      chk($sformatf("vec%0d_lv", r), olv, vt[r].elv);
      chk($sformatf("vec%0d_cmd", r), ocmd, vt[r].ecmd);
      chk($sformatf("vec%0d_data", r), odata, vt[r].edata);
      chk($sformatf("vec%0d_latency", r), first, vt[r].efirst);
      chk($sformatf("vec%0d_issued", r), 16'(int'(issued_cnt) - base), vt[r].einc);
      chk($sformatf("vec%0d_err", r), err_ch, vt[r].eerr);
    end

    // ---- fill: 9 entries accepted (one popped), then refused ----
    do_reset();
    Compute_ready = '0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, CMD_W'(32'h100 + acc), '0);
      @(negedge clk);
      a = hif.host_valid && hif.host_ready;
      if (Compute_valid[0]) chk("fill_hold_cmd", Compute_command[CMD_W-1:0], 25'h100);
      tick();
      if (a) acc++;
    end
    hif.host_valid = 1'b0;
    @(negedge clk);
    chk("fill_accepted", acc, 9);
    chk("fill_count", fifo_count, 8);
    chk("fill_ready", hif.host_ready, 0);
    chk("fill_cv", Compute_valid, 2'b01);
    chk("fill_cmd", Compute_command[CMD_W-1:0], 25'h100);
    chk("fill_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_full");

    // ---- back-to-back compute on ch1 ----
    Compute_ready = 2'b10;
    drive(0, 1, 25'h0000001, '0);
    tick();
    drive(0, 1, 25'h0000002, '0);
    tick();
    hif.host_valid = 1'b0;
    @(negedge clk);
    chk("b2b_cv0", Compute_valid, 2'b10);
    chk("b2b_cmd0", Compute_command[CMD_W +: CMD_W], 25'h1);
    tick();
    @(negedge clk);
    chk("b2b_cv1", Compute_valid, 2'b10);
    chk("b2b_cmd1", Compute_command[CMD_W +: CMD_W], 25'h2);
    tick();
    @(negedge clk);
    chk("b2b_cv2", Compute_valid, 2'b00);
    chk("b2b_issued", issued_cnt, 2);

    // ---- ready stall on ch0 ----
    Compute_ready = 2'b00;
    drive(0, 0, 25'h0ABCDE, '0);
    tick();
    hif.host_valid = 1'b0;
    tick();
    base = int'(issued_cnt);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stall_cv", Compute_valid, 2'b01);
      chk("stall_cmd", Compute_command[CMD_W-1:0], 25'h0ABCDE);
      chk("stall_issued", issued_cnt, base);
      if (k == 5) Compute_ready = 2'b01;
      tick();
    end
    @(negedge clk);
    chk("stall_done_cv", Compute_valid, 2'b00);
    chk("stall_done_issued", issued_cnt, base + 1);

    // ---- ExLdSt pulse, guard gap, then compute ----
    drive(1, 0, 25'h15, 16'hA5A5);
    tick();
    drive(0, 0, 25'h77, '0);
    tick();
    hif.host_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("gap%0d_lv", k), ExLdSt_valid, gexp_lv[k]);
      chk($sformatf("gap%0d_cv", k), Compute_valid, gexp_cv[k]);
      if (k == 0) begin
        chk("gap_lcmd", ExLdSt_command[LDST_W-1:0], 7'h15);
        chk("gap_ldata", ExLdSt_data[ROW_NUM-1:0], 16'hA5A5);
      end
      if (k >= 1 && k <= 3) chk("gap_quiet_data", ExLdSt_data, 0);
      if (k == 4) chk("gap_ccmd", Compute_command[CMD_W-1:0], 25'h77);
      tick();
    end

    // ---- randomized run against the queue model ----
    do_reset();
    exp_q.delete();
    model_issued = 0; model_err = 1'b0; last_pulse = -100; stall_prev = 1'b0;
    prev_cv = '0; prev_cmd = '0;
    drained = 1'b0;
    for (int c = 0; c < RAND_N + 400; c++) begin
      if (c < RAND_N) begin
        if ($urandom_range(0, 9) < 6)
          drive($urandom_range(0, 9) < 3, $urandom_range(0, 2), CMD_W'($urandom), ROW_NUM'($urandom));
        else
          hif.host_valid = 1'b0;
        Compute_ready = NUM_CH'($urandom);
      end else begin
        hif.host_valid = 1'b0;
        Compute_ready  = '1;
      end
      @(negedge clk);
      monitor(c);
      if (c >= RAND_N && exp_q.size() == 0 && !busy) begin
        drained = 1'b1;
        break;
      end
      tick();
    end
    chk("rnd_drained", drained, 1);

    // ---- issued_cnt wrap through 65536 dispatches ----
    do_reset();
    Compute_ready = 2'b01;
    pushed = 0; seen = 0; done = 1'b0; seen_ffff = 1'b0;
    drive(0, 0, 25'h42, '0);
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      if (seen == 65535 && !seen_ffff) begin
        chk("wrap_ffff", issued_cnt, 16'hFFFF);
        seen_ffff = 1'b1;
      end
      if (seen == 65536) begin
        chk("wrap_zero", issued_cnt, 16'h0000);
        done = 1'b1;
        break;
      end
      a  = hif.host_valid && hif.host_ready;
      hs = Compute_valid[0] && Compute_ready[0];
      tick();
      if (a) pushed++;
      if (hs) seen++;
      if (pushed == 65536) hif.host_valid = 1'b0;
    end
    chk("wrap_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
